// File: rtl/sr_latch_sequencer.sv
// Round-robin sequencer driving the active-low set/reset pins of a NAND SR latch,
// with a timed pulse, synchronized read-back check and recovery gap per command.
// Optional macro SR_SEQ_STATS_EN adds saturating set/reset/error counters.
module sr_latch_sequencer #(
    parameter int unsigned PULSE_W = 4,
    parameter int unsigned GAP_W   = 2,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [1:0]  cmd_set,
    output logic [1:0]  gnt,
    output logic        sbar,
    output logic        rbar,
    input  logic        q_fb,
    input  logic        qbar_fb,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        owner,
    output logic [1:0]  state
`ifdef SR_SEQ_STATS_EN
    ,
    output logic [15:0] set_cnt,
    output logic [15:0] rst_cnt,
    output logic [15:0] err_cnt
`endif
);

    localparam int unsigned CHECK_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_CHECK = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cmd_q, cmd_d;
    logic               owner_q, owner_d;
    logic               rr_q, rr_d;
    logic               sbar_q, sbar_d;
    logic               rbar_q, rbar_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [1:0]         qs_q, qbs_q;
    logic               sel;
    logic               match;

    // Grant is only offered in IDLE; rr_q names the requester that wins a tie.
    always_comb begin
        gnt = 2'b00;
        if (state_q == ST_IDLE) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = rr_q ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    assign sel   = gnt[1];
    assign match = (qs_q[1] == cmd_q) && (qbs_q[1] == ~cmd_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        sbar_d  = 1'b1;
        rbar_d  = 1'b1;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|(req & gnt)) begin
                    state_d = ST_PULSE;
                    cnt_d   = CNT_W'(PULSE_W);
                    cmd_d   = cmd_set[sel];
                    owner_d = sel;
                    rr_d    = ~sel;
                    sbar_d  = ~cmd_set[sel];
                    rbar_d  = cmd_set[sel];
                end
            end
            ST_PULSE: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_CHECK;
                    cnt_d   = CNT_W'(CHECK_W);
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    sbar_d = ~cmd_q;
                    rbar_d = cmd_q;
                end
            end
            ST_CHECK: begin
                cnt_d = cnt_q - CNT_W'(1);
                // done/err are registered, so they are computed one cycle early
                if (cnt_q == CNT_W'(2)) begin
                    done_d = 1'b1;
                    err_d  = ~match;
                end
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_GAP;
                    cnt_d   = CNT_W'(GAP_W);
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cmd_q   <= 1'b0;
            owner_q <= 1'b0;
            rr_q    <= 1'b0;
            sbar_q  <= 1'b1;
            rbar_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            qs_q    <= 2'b00;
            qbs_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            sbar_q  <= sbar_d;
            rbar_q  <= rbar_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            qs_q    <= {qs_q[0], q_fb};
            qbs_q   <= {qbs_q[0], qbar_fb};
        end
    end

`ifdef SR_SEQ_STATS_EN
    logic [15:0] set_cnt_q, rst_cnt_q, err_cnt_q;

    // Counters advance with the done pulse and hold at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_cnt_q <= '0;
            rst_cnt_q <= '0;
            err_cnt_q <= '0;
        end else if (done_d) begin
            if (cmd_q) begin
                if (set_cnt_q != 16'hFFFF) set_cnt_q <= set_cnt_q + 16'd1;
            end else begin
                if (rst_cnt_q != 16'hFFFF) rst_cnt_q <= rst_cnt_q + 16'd1;
            end
            if (err_d && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign set_cnt = set_cnt_q;
    assign rst_cnt = rst_cnt_q;
    assign err_cnt = err_cnt_q;
`endif

    assign sbar  = sbar_q;
    assign rbar  = rbar_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;
    assign owner = owner_q;
    assign state = state_q;

    sbar_rbar_exclusive: assert property (@(posedge clk) disable iff (rst) (sbar_q || rbar_q))
        else $fatal(1, "sr_latch_sequencer: sbar and rbar driven low together");

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// Scoreboard bench for sr_latch_sequencer with a behavioural NAND-latch model.
module tb_sr_latch_sequencer;

    localparam int PW = 4;
    localparam int GW = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [1:0] cmd_set;
    logic [1:0] gnt;
    logic       sbar, rbar, q_fb, qbar_fb;
    logic       busy, done, err, owner;
    logic [1:0] state;
`ifdef SR_SEQ_STATS_EN
    logic [15:0] set_cnt, rst_cnt, err_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic owner;
        logic cmd;
        logic err;
        int   dcyc;
    } exp_t;
    exp_t sb[$];

    logic lq    = 1'b0;
    logic stuck = 1'b0;

    sr_latch_sequencer #(.PULSE_W(PW), .GAP_W(GW), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .cmd_set(cmd_set), .gnt(gnt),
        .sbar(sbar), .rbar(rbar), .q_fb(q_fb), .qbar_fb(qbar_fb),
        .busy(busy), .done(done), .err(err), .owner(owner), .state(state)
`ifdef SR_SEQ_STATS_EN
        , .set_cnt(set_cnt), .rst_cnt(rst_cnt), .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural cross-coupled NAND latch; stuck forces Q=0/Qbar=1 on the feedback.
    always @(sbar or rbar) begin
        if (!sbar && rbar) lq = 1'b1;
        else if (sbar && !rbar) lq = 1'b0;
    end
    assign q_fb    = stuck ? 1'b0 : lq;
    assign qbar_fb = stuck ? 1'b1 : ~lq;

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at t=%0t", nm, got, want, $time);
        end
    endtask

    function automatic logic [1:0] exp_gnt(input logic [1:0] r, input int last);
        if (r == 2'b11) return (last == 0) ? 2'b10 : 2'b01;
        return r;
    endfunction

    // Observer: pin-level timing model per command, pushes expectations on each grant.
    int   last = -1;
    bit   act  = 1'b0;
    int   g    = 0;
    logic acmd = 1'b0;
    always @(negedge clk) begin
        int         ph;
        logic [1:0] es, eg;
        logic       es_sb, es_rb, es_bz;
        exp_t       e;
        if (rst) begin
            sb.delete();
            act  = 1'b0;
            last = -1;
            chk("reset_outputs", 16'({gnt, sbar, rbar, busy, done, err, owner, state}),
                16'({2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00}));
        end else begin
            ph = cyc - g;
            if (act && ph > PW + 3 + GW) act = 1'b0;
            if (!act)              es = 2'd0;
            else if (ph <= PW)     es = 2'd1;
            else if (ph <= PW + 3) es = 2'd2;
            else                   es = 2'd3;
            eg    = (es == 2'd0) ? exp_gnt(req, last) : 2'b00;
            es_sb = !((es == 2'd1) && acmd);
            es_rb = !((es == 2'd1) && !acmd);
            es_bz = (es != 2'd0);
            chk("pins", 16'({gnt, sbar, rbar, busy, state}), 16'({eg, es_sb, es_rb, es_bz, es}));
            if (eg != 2'b00) begin
                e.owner = eg[1];
                e.cmd   = cmd_set[eg[1]];
                e.err   = stuck && cmd_set[eg[1]];
                e.dcyc  = cyc + PW + 3;
                sb.push_back(e);
                act  = 1'b1;
                g    = cyc;
                acmd = e.cmd;
                last = int'(eg[1]);
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents done.
    int ns = 0, nr = 0, ne = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            ns = 0; nr = 0; ne = 0;
        end else if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 16'(done), 16'(0));
            end else begin
                e = sb.pop_front();
                chk("done_owner_err", 16'({owner, err}), 16'({e.owner, e.err}));
                chk("done_cycle", 16'(cyc), 16'(e.dcyc));
                if (e.cmd) ns++; else nr++;
                if (e.err) ne++;
`ifdef SR_SEQ_STATS_EN
                chk("set_cnt", set_cnt, 16'(ns));
                chk("rst_cnt", rst_cnt, 16'(nr));
                chk("err_cnt", err_cnt, 16'(ne));
`endif
            end
        end else if (sb.size() != 0 && cyc > sb[0].dcyc) begin
            e = sb.pop_front();
            chk("missing_done", 16'(done), 16'(1));
        end
    end

    task automatic issue(input int i, input logic c);
        bit seen = 1'b0;
        req[i]     = 1'b1;
        cmd_set[i] = c;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (gnt[i]) seen = 1'b1;
        end
        if (!seen) chk("grant_timeout", 16'(gnt), 16'(2'b01 << i));
        @(posedge clk);
        #1 req[i] = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) ok = 1'b1;
        end
        if (!ok) chk("idle_timeout", 16'(busy), 16'(0));
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] tk;
        bit         seen;
        rst     = 1'b1;
        req     = 2'b00;
        cmd_set = 2'b00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Quiet idle period after reset.
        repeat (20) @(posedge clk);

        // Single set command from requester 0.
        #1;
        issue(0, 1'b1);
        wait_idle(30);
        chk("latch_q_after_set", 16'(lq), 16'(1));

        // Both requesting: alternation starting from requester 0.
        pulse_reset();
        req     = 2'b11;
        cmd_set = 2'b10;
        for (int n = 0; n < 4; n++) begin
            seen = 1'b0;
            for (int k = 0; k < 15 && !seen; k++) begin
                @(negedge clk);
                if (gnt != 2'b00) seen = 1'b1;
            end
            chk("alt_grant", 16'(gnt), (n % 2 == 1) ? 16'(2'b10) : 16'(2'b01));
            @(posedge clk);
        end
        #1 req = 2'b00;
        wait_idle(30);

        // Stuck feedback gives err on a set; the next command is still served.
        stuck = 1'b1;
        issue(0, 1'b1);
        wait_idle(30);
        stuck = 1'b0;
        issue(1, 1'b0);
        wait_idle(30);
        chk("latch_q_after_reset", 16'(lq), 16'(0));

        // Async reset in the second pulse cycle.
        req[1]     = 1'b1;
        cmd_set[1] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 15 && !seen; k++) begin
            @(negedge clk);
            if (gnt[1]) seen = 1'b1;
        end
        if (!seen) chk("grant_timeout", 16'(gnt), 16'(2'b10));
        @(posedge clk);
        #1 req = 2'b00;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_mid_pulse", 16'({sbar, rbar, state, busy, done}), 16'({1'b1, 1'b1, 2'b00, 1'b0, 1'b0}));
        @(posedge clk);
        #1 rst = 1'b0;
        req     = 2'b11;
        cmd_set = 2'b01;
        seen = 1'b0;
        for (int k = 0; k < 15 && !seen; k++) begin
            @(negedge clk);
            if (gnt != 2'b00) seen = 1'b1;
        end
        chk("first_after_rst", 16'(gnt), 16'(2'b01));
        @(posedge clk);
        #1 req = 2'b00;
        wait_idle(30);

        // Randomized traffic, requests held until granted with occasional drops.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            tk = req & gnt;
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (tk[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req[i]     = 1'b1;
                        cmd_set[i] = 1'($urandom_range(0, 1));
                    end
                end else if ($urandom_range(0, 29) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
        req = 2'b00;
        wait_idle(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
